// File: rtl/mipi_csi_pkg.sv
// Shared CSI constants: packet type codes, RAW group sizes and the depacker FSM states.
// Also used by the packet decoder for its type constants.
package mipi_csi_pkg;

  localparam logic [2:0] PT_RAW10 = 3'b011;
  localparam logic [2:0] PT_RAW12 = 3'b100;

  localparam int unsigned GRP_RAW10 = 5;
  localparam int unsigned GRP_RAW12 = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_SKIP,
    ST_DONE
  } depack_state_e;

  function automatic logic is_supported(input logic [2:0] pt);
    return (pt == PT_RAW10) || (pt == PT_RAW12);
  endfunction

  function automatic logic [3:0] group_bytes(input logic [2:0] pt);
    return (pt == PT_RAW12) ? 4'(GRP_RAW12) : 4'(GRP_RAW10);
  endfunction

endpackage

// File: rtl/mipi_csi_raw_unpack_comb.sv
// Pure combinational RAW10/RAW12 mapping of the oldest 6 buffered bytes to 4 pixels.
// Any type other than RAW12 uses the RAW10 mapping; the parent only registers supported types.
module mipi_csi_raw_unpack_comb
  import mipi_csi_pkg::*;
#(
  parameter int PIXEL_W = 12
) (
  input  logic [47:0]          win_i,
  input  logic [2:0]           type_i,
  output logic [4*PIXEL_W-1:0] pix_o
);

  logic [7:0]  b [6];
  logic [11:0] p [4];

  always_comb begin
    for (int n = 0; n < 6; n++) begin
      b[n] = win_i[8*n +: 8];
    end
    if (type_i == PT_RAW12) begin
      p[0] = {b[0], b[2][3:0]};
      p[1] = {b[1], b[2][7:4]};
      p[2] = {b[3], b[5][3:0]};
      p[3] = {b[4], b[5][7:4]};
    end else begin
      // RAW10: byte 4 carries the two LSBs of each of the four pixels.
      for (int n = 0; n < 4; n++) begin
        p[n] = {2'b00, b[n], b[4][2*n +: 2]};
      end
    end
    pix_o = '0;
    for (int n = 0; n < 4; n++) begin
      pix_o[PIXEL_W*n +: PIXEL_W] = PIXEL_W'(p[n]);
    end
  end

endmodule

// File: rtl/mipi_csi_raw_depacker.sv
// Unpacks RAW10/RAW12 CSI payload words into 4-pixel beats and counts groups per line.
// Holds up to 8 bytes; at most one group is extracted per accepted word.
module mipi_csi_raw_depacker
  import mipi_csi_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int PIXEL_W = 12,
  parameter int CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 data_valid_i,
  input  logic [8*LANES-1:0]   data_i,
  input  logic [2:0]           packet_type_i,
  output logic                 pixel_valid_o,
  output logic [4*PIXEL_W-1:0] pixel_data_o,
  output logic [CNT_W-1:0]     pixel_count_o,
  output logic                 line_done_o
);

  localparam int BUF_W = 64;
  localparam int CMB_W = BUF_W + 8*LANES;

  depack_state_e        state_q, state_d;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [3:0]           level_q, level_d;
  logic [2:0]           type_q, type_d;
  logic                 vld_q, vld_d;
  logic [4*PIXEL_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [2:0]           type_eff;
  logic [3:0]           grp;
  logic [CMB_W-1:0]     comb;
  logic [3:0]           comb_lvl;
  logic                 take;
  logic [BUF_W-1:0]     rem;
  logic [4*PIXEL_W-1:0] pix_unp;
  logic                 process;

  // In IDLE the first word is unpacked with the incoming type before it is latched.
  assign type_eff = (state_q == ST_IDLE) ? packet_type_i : type_q;
  assign grp      = group_bytes(type_eff);
  assign comb     = {{(CMB_W-BUF_W){1'b0}}, buf_q}
                  | ({{BUF_W{1'b0}}, data_i} << {level_q, 3'b000});
  assign comb_lvl = level_q + 4'(LANES);
  assign take     = (comb_lvl >= grp);
  assign rem      = BUF_W'(comb >> {grp, 3'b000});

  mipi_csi_raw_unpack_comb #(
    .PIXEL_W (PIXEL_W)
  ) u_unpack (
    .win_i  (comb[47:0]),
    .type_i (type_eff),
    .pix_o  (pix_unp)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    level_d = level_q;
    type_d  = type_q;
    vld_d   = 1'b0;
    pix_d   = pix_q;
    cnt_d   = cnt_q;
    process = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (data_valid_i) begin
          if (is_supported(packet_type_i)) begin
            state_d = ST_ACTIVE;
            type_d  = packet_type_i;
            cnt_d   = '0;
            process = 1'b1;
          end else begin
            state_d = ST_SKIP;
          end
        end
      end
      ST_ACTIVE: begin
        // A type change while valid ends the line; that word is dropped.
        if (!data_valid_i || (packet_type_i != type_q)) begin
          state_d = ST_DONE;
          buf_d   = '0;
          level_d = '0;
        end else begin
          process = 1'b1;
        end
      end
      ST_SKIP: begin
        if (!data_valid_i) state_d = ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        buf_d   = '0;
        level_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (process) begin
      if (take) begin
        vld_d   = 1'b1;
        pix_d   = pix_unp;
        buf_d   = rem;
        level_d = comb_lvl - grp;
        if (!(&cnt_d)) cnt_d = cnt_d + 1'b1;
      end else begin
        buf_d   = comb[BUF_W-1:0];
        level_d = comb_lvl;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      level_q <= '0;
      type_q  <= '0;
      vld_q   <= 1'b0;
      pix_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      level_q <= level_d;
      type_q  <= type_d;
      vld_q   <= vld_d;
      pix_q   <= pix_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pixel_valid_o = vld_q;
  assign pixel_data_o  = pix_q;
  assign pixel_count_o = cnt_q;
  assign line_done_o   = (state_q == ST_DONE);

endmodule
